alu_arbiter: RTL and testbench

Shares one `alu` instance between two requesters: requester 0 (execute stage) and requester 1 (load/store address generation / CSR helper). Per-requester valid/grant handshake, round-robin or fixed-priority arbitration, and a two-stage registered pipeline around the combinational ALU. Accepts one operation per clock; each result returns to its originating requester with fixed latency.

---
 rtl/alu_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU behind a
// two-stage registered pipeline, round-robin or fixed priority.
module alu_arbiter #(
  parameter int PRIORITY_MODE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_grant_0,
  output logic        req_grant_1,
  input  logic [31:0] source_0,
  input  logic [31:0] source_1,
  input  logic [31:0] arg_1_0,
  input  logic [31:0] arg_1_1,
  input  logic [2:0]  alu_op_0,
  input  logic [2:0]  alu_op_1,
  input  logic        is_alt_0,
  input  logic        is_alt_1,
  output logic        rsp_valid_0,
  output logic        rsp_valid_1,
  output logic [31:0] result
);

  localparam bit FIXED = (PRIORITY_MODE != 0);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SLL  = 3'd1;
  localparam logic [2:0] OP_SLT  = 3'd2;
  localparam logic [2:0] OP_SLTU = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SRL  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_AND  = 3'd7;

  logic        last;
  logic        open;
  logic        pick_0;

  logic        s1_valid;
  logic        s1_id;
  logic        s1_alt;
  logic [2:0]  s1_op;
  logic [31:0] s1_a;
  logic [31:0] s1_b;

  logic        s2_valid;
  logic        s2_id;

  logic [31:0] alu_out;
  logic [4:0]  shamt;

  // Arbitration: only valids, last, flush and reset feed the grants.
  always_comb begin
    open = !reset && !flush;
    if (FIXED)
      pick_0 = req_valid_0;
    else
      pick_0 = req_valid_0 && (!req_valid_1 || last);
    req_grant_0 = open && pick_0;
    req_grant_1 = open && req_valid_1 && !pick_0;
  end

  // Shared ALU, driven from the stage-1 operand registers.
  always_comb begin
    alu_out = '0;
    shamt   = s1_b[4:0];
    unique case (s1_op)
      OP_ADD:  alu_out = s1_alt ? s1_a - s1_b : s1_a + s1_b;
      OP_SLL:  alu_out = s1_a << shamt;
      OP_SLT:  alu_out = {31'b0, $signed(s1_a) < $signed(s1_b)};
      OP_SLTU: alu_out = {31'b0, s1_a < s1_b};
      OP_XOR:  alu_out = s1_a ^ s1_b;
      OP_SRL:  alu_out = s1_alt ? $unsigned($signed(s1_a) >>> shamt)
                                : s1_a >> shamt;
      OP_OR:   alu_out = s1_a | s1_b;
      OP_AND:  alu_out = s1_a & s1_b;
    endcase
  end

  // Round-robin pointer and valid/id tracking through both stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      last     <= 1'b1;
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s2_valid <= 1'b0;
      s2_id    <= 1'b0;
    end else begin
      if (req_grant_0)
        last <= 1'b0;
      else if (req_grant_1)
        last <= 1'b1;
      s1_valid <= req_grant_0 || req_grant_1;
      if (req_grant_0 || req_grant_1)
        s1_id <= req_grant_1;
      s2_valid <= s1_valid && !flush;
      s2_id    <= s1_id;
    end
  end

  // Operand capture on grant; held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_a   <= '0;
      s1_b   <= '0;
      s1_op  <= '0;
      s1_alt <= 1'b0;
    end else if (req_grant_0) begin
      s1_a   <= source_0;
      s1_b   <= arg_1_0;
      s1_op  <= alu_op_0;
      s1_alt <= is_alt_0;
    end else if (req_grant_1) begin
      s1_a   <= source_1;
      s1_b   <= arg_1_1;
      s1_op  <= alu_op_1;
      s1_alt <= is_alt_1;
    end
  end

  // Result register only moves when stage 1 carries an op.
  always_ff @(posedge clk) begin
    if (reset)
      result <= '0;
    else if (s1_valid)
      result <= alu_out;
  end

  assign rsp_valid_0 = s2_valid && !s2_id;
  assign rsp_valid_1 = s2_valid && s2_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors and handshake sequences
// for the shared-ALU arbiter in both priority modes.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        req_valid_0, req_valid_1;
  logic [31:0] source_0, source_1;
  logic [31:0] arg_1_0, arg_1_1;
  logic [2:0]  alu_op_0, alu_op_1;
  logic        is_alt_0, is_alt_1;

  logic        req_grant_0, req_grant_1;
  logic        rsp_valid_0, rsp_valid_1;
  logic [31:0] result;

  logic        fp_grant_0, fp_grant_1;
  logic        fp_rsp_0, fp_rsp_1;
  logic [31:0] fp_result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.PRIORITY_MODE(0)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_grant_0(req_grant_0), .req_grant_1(req_grant_1),
    .source_0(source_0), .source_1(source_1),
    .arg_1_0(arg_1_0), .arg_1_1(arg_1_1),
    .alu_op_0(alu_op_0), .alu_op_1(alu_op_1),
    .is_alt_0(is_alt_0), .is_alt_1(is_alt_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .result(result)
  );

  alu_arbiter #(.PRIORITY_MODE(1)) dut_fp (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_grant_0(fp_grant_0), .req_grant_1(fp_grant_1),
    .source_0(source_0), .source_1(source_1),
    .arg_1_0(arg_1_0), .arg_1_1(arg_1_1),
    .alu_op_0(alu_op_0), .alu_op_1(alu_op_1),
    .is_alt_0(is_alt_0), .is_alt_1(is_alt_1),
    .rsp_valid_0(fp_rsp_0), .rsp_valid_1(fp_rsp_1),
    .result(fp_result)
  );

  typedef struct {
    logic [2:0]  op;
    logic        alt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [2:0] op, input logic alt,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e);
    vec_t v;
    v.op = op; v.alt = alt; v.a = a; v.b = b; v.e = e;
    tv.push_back(v);
  endtask

  task automatic addx(input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e);
    add(op, 1'b0, a, b, e);
    add(op, 1'b1, a, b, e);
  endtask

  task automatic idle();
    req_valid_0 = 0; req_valid_1 = 0; flush = 0;
  endtask

  initial begin
    // hand-computed op sweep
    add(0, 0, 32'h7FFFFFFF, 1, 32'h80000000);
    add(0, 1, 32'h7FFFFFFF, 1, 32'h7FFFFFFE);
    addx(1, 32'h7FFFFFFF, 1, 32'hFFFFFFFE);
    addx(2, 32'h7FFFFFFF, 1, 32'h0);
    addx(3, 32'h7FFFFFFF, 1, 32'h0);
    addx(4, 32'h7FFFFFFF, 1, 32'h7FFFFFFE);
    add(5, 0, 32'h7FFFFFFF, 1, 32'h3FFFFFFF);
    add(5, 1, 32'h7FFFFFFF, 1, 32'h3FFFFFFF);
    addx(6, 32'h7FFFFFFF, 1, 32'h7FFFFFFF);
    addx(7, 32'h7FFFFFFF, 1, 32'h1);
    add(0, 0, 32'hFFFFFFFF, 31, 32'h0000001E);
    add(0, 1, 32'hFFFFFFFF, 31, 32'hFFFFFFE0);
    addx(1, 32'hFFFFFFFF, 31, 32'h80000000);
    addx(2, 32'hFFFFFFFF, 31, 32'h1);
    addx(3, 32'hFFFFFFFF, 31, 32'h0);
    addx(4, 32'hFFFFFFFF, 31, 32'hFFFFFFE0);
    add(5, 0, 32'hFFFFFFFF, 31, 32'h1);
    add(5, 1, 32'hFFFFFFFF, 31, 32'hFFFFFFFF);
    addx(6, 32'hFFFFFFFF, 31, 32'hFFFFFFFF);
    addx(7, 32'hFFFFFFFF, 31, 32'h1F);
    for (int op = 0; op < 8; op++)
      addx(op[2:0], 0, 0, 0);
    addx(2, 32'hFFFFFFFF, 0, 32'h1);
    addx(3, 32'hFFFFFFFF, 0, 32'h0);

    reset = 1; idle();
    source_0 = 0; source_1 = 0; arg_1_0 = 0; arg_1_1 = 0;
    alu_op_0 = 0; alu_op_1 = 0; is_alt_0 = 0; is_alt_1 = 0;

    // reset state, grant suppressed during reset
    cyc();
    req_valid_0 = 1; req_valid_1 = 1;
    #1;
    chk("rst_gnt0", req_grant_0, 0);
    chk("rst_gnt1", req_grant_1, 0);
    chk("rst_rsp0", rsp_valid_0, 0);
    chk("rst_rsp1", rsp_valid_1, 0);
    chk("rst_result", result, 0);
    cyc();
    reset = 0; idle();

    // single ADD 5+7, latency 2
    cyc();
    req_valid_0 = 1; source_0 = 5; arg_1_0 = 7;
    alu_op_0 = 0; is_alt_0 = 0;
    #1;
    chk("add_gnt0", req_grant_0, 1);
    chk("add_gnt1", req_grant_1, 0);
    cyc();
    req_valid_0 = 0;
    #1;
    chk("add_rsp0_n1", rsp_valid_0, 0);
    cyc();
    #1;
    chk("add_rsp0_n2", rsp_valid_0, 1);
    chk("add_result", result, 12);
    chk("add_rsp1", rsp_valid_1, 0);
    cyc();
    #1;
    chk("add_rsp0_n3", rsp_valid_0, 0);
    chk("add_hold", result, 12);

    // reset so contention starts from last=1
    reset = 1;
    cyc();
    reset = 0;
    source_0 = 10; arg_1_0 = 3; alu_op_0 = 0; is_alt_0 = 1;
    source_1 = 32'h80000000; arg_1_1 = 4;
    alu_op_1 = 5; is_alt_1 = 1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      req_valid_0 = (k < 6); req_valid_1 = (k < 6);
      #1;
      chk($sformatf("rr_gnt0_%0d", k), req_grant_0,
          32'(k < 6 && k % 2 == 0));
      chk($sformatf("rr_gnt1_%0d", k), req_grant_1,
          32'(k < 6 && k % 2 == 1));
      if (k >= 2) begin
        chk($sformatf("rr_rsp0_%0d", k), rsp_valid_0,
            32'(k % 2 == 0));
        chk($sformatf("rr_rsp1_%0d", k), rsp_valid_1,
            32'(k % 2 == 1));
        chk($sformatf("rr_res_%0d", k), result,
            (k % 2 == 0) ? 32'd7 : 32'hF8000000);
      end else begin
        chk($sformatf("rr_norsp_%0d", k),
            32'(rsp_valid_0 | rsp_valid_1), 0);
      end
    end
    idle();

    // fixed priority: req0 always wins, req1 on first gap
    for (int k = 0; k < 6; k++) begin
      cyc();
      req_valid_0 = (k < 3); req_valid_1 = (k < 4);
      #1;
      chk($sformatf("fp_gnt0_%0d", k), fp_grant_0,
          32'(k < 3));
      chk($sformatf("fp_gnt1_%0d", k), fp_grant_1,
          32'(k == 3));
      if (k == 5) begin
        chk("fp_rsp1", fp_rsp_1, 1);
        chk("fp_rsp0", fp_rsp_0, 0);
        chk("fp_res", fp_result, 32'hF8000000);
      end
    end
    idle();
    cyc(); cyc();

    // flush: older response survives, younger op dropped
    cyc();
    req_valid_0 = 1; source_0 = 1; arg_1_0 = 1;
    alu_op_0 = 0; is_alt_0 = 0;
    #1;
    chk("fl_gnt0_a", req_grant_0, 1);
    cyc();
    req_valid_0 = 0; req_valid_1 = 1;
    source_1 = 1; arg_1_1 = 32'hFFFFFFFF;
    alu_op_1 = 3; is_alt_1 = 0;
    #1;
    chk("fl_gnt1", req_grant_1, 1);
    cyc();
    req_valid_1 = 0; req_valid_0 = 1; flush = 1;
    source_0 = 5; arg_1_0 = 7;
    #1;
    chk("fl_no_gnt0", req_grant_0, 0);
    chk("fl_no_gnt1", req_grant_1, 0);
    chk("fl_old_rsp0", rsp_valid_0, 1);
    chk("fl_old_res", result, 2);
    cyc();
    flush = 0;
    #1;
    chk("fl_gnt0_b", req_grant_0, 1);
    chk("fl_killed_rsp1", rsp_valid_1, 0);
    cyc();
    req_valid_0 = 0;
    #1;
    chk("fl_quiet0", rsp_valid_0, 0);
    chk("fl_quiet1", rsp_valid_1, 0);
    cyc();
    #1;
    chk("fl_new_rsp0", rsp_valid_0, 1);
    chk("fl_new_res", result, 12);

    // reset right after a grant
    cyc();
    req_valid_0 = 1; source_0 = 3; arg_1_0 = 4;
    #1;
    chk("mr_gnt0", req_grant_0, 1);
    cyc();
    reset = 1;
    #1;
    chk("mr_rst_gnt0", req_grant_0, 0);
    cyc();
    reset = 0; req_valid_0 = 0;
    #1;
    chk("mr_rsp0", rsp_valid_0, 0);
    chk("mr_rsp1", rsp_valid_1, 0);
    chk("mr_result", result, 0);
    cyc();
    req_valid_0 = 1; req_valid_1 = 1;
    #1;
    chk("mr_rsp0_b", rsp_valid_0, 0);
    chk("mr_first_gnt0", req_grant_0, 1);
    chk("mr_first_gnt1", req_grant_1, 0);
    cyc();
    idle();
    cyc(); cyc(); cyc();

    // op sweep on req0
    foreach (tv[i]) begin
      cyc();
      req_valid_0 = 1;
      source_0 = tv[i].a; arg_1_0 = tv[i].b;
      alu_op_0 = tv[i].op; is_alt_0 = tv[i].alt;
      cyc();
      req_valid_0 = 0;
      cyc();
      #1;
      chk($sformatf("sw_rsp_%0d", i), rsp_valid_0, 1);
      chk($sformatf("sw_op%0d_alt%0d_%0d", tv[i].op,
          tv[i].alt, i), result, tv[i].e);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
